// File: rtl/param_ram_bellek.sv
// param_ram_bellek: parametrised byte-lane data RAM with range/alignment-checked valid/ready requests (RAM_CLEAR_ON_RESET_EN zeroes it after reset).
// Latency: one response per accepted request, RD_LAT (1..4) cycles after accept, in order; writes return an ack.
// Backpressure: req_ready_o is low only during reset (and the clear sweep); responses cannot be stalled.
module param_ram_bellek #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 512,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RD_LAT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  init_done_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
`ifdef RAM_CLEAR_ON_RESET_EN
        ST_CLEAR = 2'd1,
`endif
        ST_READY = 2'd2
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [DATA_W-1:0] dat;
    } rsp_stage_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    rsp_stage_t        pipe_q [RD_LAT];

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx_full;
    logic [IDX_W-1:0]  idx;
    logic              addr_err;
    logic              acc;
    logic              wr_en;

    // Offsets below BASE_ADDR wrap to huge values and fall out of range naturally.
    assign off      = req_addr_i - BASE_ADDR;
    assign idx_full = off >> OFF_W;
    assign idx      = idx_full[IDX_W-1:0];
    assign addr_err = ((off & ALIGN_MASK) != '0) || (idx_full >= ADDR_W'(DEPTH));
    assign acc      = req_valid_i && req_ready_o && rst_ni;
    assign wr_en    = acc && req_we_i && !addr_err;

`ifdef RAM_CLEAR_ON_RESET_EN
    logic [IDX_W-1:0] clr_cnt_q;
    logic             clr_we;

    assign clr_we = rst_ni && (state_q == ST_CLEAR);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            clr_cnt_q <= '0;
        end else if (clr_we) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        init_done_o = 1'b0;
        case (state_q)
            ST_RST: begin
`ifdef RAM_CLEAR_ON_RESET_EN
                state_d = ST_CLEAR;
`else
                state_d = ST_READY;
`endif
            end
`ifdef RAM_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
`endif
            ST_READY: begin
                req_ready_o = 1'b1;
                init_done_o = 1'b1;
            end
            default: state_d = ST_RST;
        endcase
    end

    // Storage has no reset; only the optional sweep or accepted writes touch it.
    always_ff @(posedge clk_i) begin
`ifdef RAM_CLEAR_ON_RESET_EN
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end
`endif
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be_i[b]) begin
                    mem[idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].vld <= acc;
            pipe_q[0].err <= acc && addr_err;
            pipe_q[0].dat <= (acc && !req_we_i && !addr_err) ? mem[idx] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rsp_valid_o = pipe_q[RD_LAT-1].vld;
    assign rsp_err_o   = pipe_q[RD_LAT-1].vld && pipe_q[RD_LAT-1].err;
    assign rsp_rdata_o = pipe_q[RD_LAT-1].vld ? pipe_q[RD_LAT-1].dat : '0;

endmodule
